sd_axil_bridge: RTL and testbench

// - AXI4-Lite slave to spisd register/buffer bus adapter; drives sd_bus spisd_* directly upstream of it.
// - Serialises AXI reads and writes into single spisd accesses.
// - Returns sd_bus read data after its fixed registered read latency.

---
 rtl/sd_axil_bridge.sv | 160 ++++++++++++++++
 tb/tb_sd_axil_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_axil_bridge.sv
// AXI4-Lite slave to spisd register/buffer bus adapter, one outstanding access at a time.
// Optional SD_BRIDGE_ADDR_CHECK_EN: addr[15:14]==2'b01 is not forwarded and answers SLVERR.
module sd_axil_bridge #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic                msoc_clk,
  input  logic                sys_rst,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic                spisd_en,
  output logic                spisd_we,
  output logic [DATA_W/8-1:0] spisd_be,
  output logic [ADDR_W-1:0]   spisd_addr,
  output logic [DATA_W-1:0]   spisd_wrdata,
  input  logic [DATA_W-1:0]   spisd_rddata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP} state_t;

  state_t           state;
  logic             prio_wr;
  logic             unmapped;
  logic [CNT_W-1:0] cnt;
  logic             wr_pend, rd_pend, take_wr, take_rd;
  logic             hole_aw, hole_ar;

`ifdef SD_BRIDGE_ADDR_CHECK_EN
  assign hole_aw = (s_awaddr[15:14] == 2'b01);
  assign hole_ar = (s_araddr[15:14] == 2'b01);
`else
  assign hole_aw = 1'b0;
  assign hole_ar = 1'b0;
`endif

  // AW is only taken together with W; prio breaks ties and flips only on a real tie.
  assign wr_pend = s_awvalid & s_wvalid;
  assign rd_pend = s_arvalid;
  assign take_wr = wr_pend & (~rd_pend | prio_wr);
  assign take_rd = rd_pend & (~wr_pend | ~prio_wr);

  always_ff @(posedge msoc_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      prio_wr      <= 1'b1;
      unmapped     <= 1'b0;
      cnt          <= '0;
      s_awready    <= 1'b0;
      s_wready     <= 1'b0;
      s_arready    <= 1'b0;
      s_bvalid     <= 1'b0;
      s_bresp      <= OKAY;
      s_rvalid     <= 1'b0;
      s_rresp      <= OKAY;
      s_rdata      <= '0;
      spisd_en     <= 1'b0;
      spisd_we     <= 1'b0;
      spisd_be     <= '0;
      spisd_addr   <= '0;
      spisd_wrdata <= '0;
    end else begin
      spisd_en <= 1'b0;
      spisd_we <= 1'b0;
      case (state)
        IDLE: begin
          if (take_wr) begin
            s_awready    <= 1'b1;
            s_wready     <= 1'b1;
            spisd_addr   <= s_awaddr;
            spisd_wrdata <= s_wdata;
            spisd_be     <= s_wstrb;
            unmapped     <= hole_aw;
            if (rd_pend) prio_wr <= 1'b0;
            state        <= WR_ISSUE;
          end else if (take_rd) begin
            s_arready  <= 1'b1;
            spisd_addr <= s_araddr;
            spisd_be   <= '1;
            unmapped   <= hole_ar;
            if (wr_pend) prio_wr <= 1'b1;
            state      <= RD_ISSUE;
          end
        end
        // First cycle carries the AW/W handshake, second is the spisd strobe cycle.
        WR_ISSUE: begin
          if (s_awready) begin
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            if (spisd_be == '0) begin
              s_bvalid <= 1'b1;
              s_bresp  <= OKAY;
              state    <= WR_RESP;
            end else begin
              spisd_en <= ~unmapped;
              spisd_we <= ~unmapped;
            end
          end else begin
            s_bvalid <= 1'b1;
            s_bresp  <= unmapped ? SLVERR : OKAY;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_ISSUE: begin
          s_arready <= 1'b0;
          spisd_en  <= ~unmapped;
          cnt       <= CNT_W'(RD_LAT);
          state     <= RD_WAIT;
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            s_rvalid <= 1'b1;
            s_rdata  <= unmapped ? '0 : spisd_rddata;
            s_rresp  <= unmapped ? SLVERR : OKAY;
            state    <= RD_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_be_w;
  assign unused_be_w = (BE_W == 0);

endmodule

// File: tb/tb_sd_axil_bridge.sv
// Self-checking bench for sd_axil_bridge: vector table, spisd access scoreboard, corner-case sequences.
module tb_sd_axil_bridge;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;
  localparam int RD_LAT = 1;

  logic        msoc_clk = 1'b0;
  logic        sys_rst  = 1'b1;
  logic [15:0] s_awaddr = '0, s_araddr = '0;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
  logic [63:0] s_wdata = '0;
  logic [7:0]  s_wstrb = '0;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [63:0] s_rdata;
  logic        spisd_en, spisd_we;
  logic [7:0]  spisd_be;
  logic [15:0] spisd_addr;
  logic [63:0] spisd_wrdata;
  logic [63:0] spisd_rddata = '0;

  always #5 msoc_clk = ~msoc_clk;

  sd_axil_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .msoc_clk(msoc_clk), .sys_rst(sys_rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .spisd_en(spisd_en), .spisd_we(spisd_we), .spisd_be(spisd_be), .spisd_addr(spisd_addr),
    .spisd_wrdata(spisd_wrdata), .spisd_rddata(spisd_rddata)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // sd_bus model: one-cycle registered read, poison value outside the valid cycle.
  logic [63:0] mem [int];

  function automatic logic [63:0] mem_rd(input int k);
    if (mem.exists(k)) return mem[k];
    case (k)
      16'h0010 >> 3: return 64'hA5;
      16'h4000 >> 3: return 64'h77;
      16'h8000 >> 3: return 64'h1234;
      default:       return 64'h0;
    endcase
  endfunction

  always @(posedge msoc_clk) begin
    logic [63:0] w;
    spisd_rddata <= 64'hDEAD_BEEF_DEAD_BEEF;
    if (spisd_en) begin
      if (spisd_we) begin
        w = mem_rd(int'(spisd_addr[15:3]));
        for (int b = 0; b < 8; b++)
          if (spisd_be[b]) w[b*8 +: 8] = spisd_wrdata[b*8 +: 8];
        mem[int'(spisd_addr[15:3])] = w;
      end else begin
        spisd_rddata <= mem_rd(int'(spisd_addr[15:3]));
      end
    end
  end

  // Scoreboard of expected spisd accesses, pushed when AXI stimulus is driven.
  typedef struct packed {logic we; logic [15:0] addr; logic [7:0] be; logic [63:0] data;} acc_t;
  acc_t exp_q[$];
  logic we_log[$];
  int   n_en = 0;
  bit   sb_off = 1'b0;

  always @(negedge msoc_clk) begin
    acc_t a;
    if (spisd_en) begin
      n_en++;
      we_log.push_back(spisd_we);
      if (!sb_off) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spisd_unexpected: access at %0h with nothing expected", spisd_addr);
        end else begin
          a = exp_q.pop_front();
          chk("spisd_we", spisd_we, a.we);
          chk("spisd_addr", spisd_addr, a.addr);
          chk("spisd_be", spisd_be, a.be);
          if (a.we) chk("spisd_wrdata", spisd_wrdata, a.data);
        end
      end
    end
  end

  // AXI master tasks: entered and left on a negedge.
  task automatic axi_wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s,
                        output logic [1:0] resp, output int lat);
    int n = 0;
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1'b1; s_wvalid = 1'b1;
    while (!s_awready && n < 50) begin @(negedge msoc_clk); n++; end
    if (!s_awready) timeout("aw_accept");
    else chk("wready_with_awready", s_wready, 1'b1);
    @(negedge msoc_clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; lat = 1;
    while (!s_bvalid && lat < 50) begin @(negedge msoc_clk); lat++; end
    if (!s_bvalid) timeout("bvalid");
    resp = s_bresp;
    s_bready = 1'b1;
    @(negedge msoc_clk);
    s_bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [15:0] a, output logic [63:0] d, output logic [1:0] resp,
                        output int lat);
    int n = 0;
    s_araddr = a; s_arvalid = 1'b1;
    while (!s_arready && n < 50) begin @(negedge msoc_clk); n++; end
    if (!s_arready) timeout("ar_accept");
    @(negedge msoc_clk);
    s_arvalid = 1'b0; lat = 1;
    while (!s_rvalid && lat < 50) begin @(negedge msoc_clk); lat++; end
    if (!s_rvalid) timeout("rvalid");
    d = s_rdata; resp = s_rresp;
    s_rready = 1'b1;
    @(negedge msoc_clk);
    s_rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_resp;
    bit          exp_en;
    int          exp_lat;
  } vec_t;

  vec_t vec[9];

  initial begin
    logic [1:0]  resp;
    logic [63:0] rd;
    int          lat, en0, n;
    bit          saw;

    vec[0] = '{1'b1, 16'h0008, 64'h8000_1000, 8'hFF, 64'h0, 2'b00, 1'b1, 2};
    vec[1] = '{1'b0, 16'h0010, 64'h0, 8'h00, 64'hA5, 2'b00, 1'b1, 3};
    vec[2] = '{1'b0, 16'h0008, 64'h0, 8'h00, 64'h8000_1000, 2'b00, 1'b1, 3};
    vec[3] = '{1'b1, 16'h0008, 64'hFF, 8'h01, 64'h0, 2'b00, 1'b1, 2};
    vec[4] = '{1'b0, 16'h0008, 64'h0, 8'h00, 64'h8000_10FF, 2'b00, 1'b1, 3};
    vec[5] = '{1'b1, 16'h0018, 64'h1122_3344_5566_7788, 8'hF0, 64'h0, 2'b00, 1'b1, 2};
    vec[6] = '{1'b0, 16'h0018, 64'h0, 8'h00, 64'h1122_3344_0000_0000, 2'b00, 1'b1, 3};
`ifdef SD_BRIDGE_ADDR_CHECK_EN
    vec[7] = '{1'b1, 16'h4000, 64'hCAFE, 8'hFF, 64'h0, 2'b10, 1'b0, 2};
    vec[8] = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'h0, 2'b10, 1'b0, 3};
`else
    vec[7] = '{1'b1, 16'h4000, 64'hCAFE, 8'hFF, 64'h0, 2'b00, 1'b1, 2};
    vec[8] = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hCAFE, 2'b00, 1'b1, 3};
`endif

    // Reset state
    repeat (3) @(negedge msoc_clk);
    chk("rst_awready", s_awready, 1'b0);
    chk("rst_wready", s_wready, 1'b0);
    chk("rst_arready", s_arready, 1'b0);
    chk("rst_bvalid", s_bvalid, 1'b0);
    chk("rst_rvalid", s_rvalid, 1'b0);
    chk("rst_spisd_en", spisd_en, 1'b0);
    chk("rst_spisd_we", spisd_we, 1'b0);
    chk("rst_spisd_addr", spisd_addr, 16'h0);
    chk("rst_rdata", s_rdata, 64'h0);
    chk("rst_bresp", s_bresp, 2'b00);
    chk("rst_rresp", s_rresp, 2'b00);
    sys_rst = 1'b0;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      en0 = n_en;
      if (vec[i].exp_en)
        exp_q.push_back(acc_t'{we: vec[i].wr, addr: vec[i].addr,
                               be: vec[i].wr ? vec[i].strb : 8'hFF, data: vec[i].data});
      if (vec[i].wr) begin
        axi_wr(vec[i].addr, vec[i].data, vec[i].strb, resp, lat);
        chk($sformatf("v%0d_bresp", i), resp, vec[i].exp_resp);
      end else begin
        axi_rd(vec[i].addr, rd, resp, lat);
        chk($sformatf("v%0d_rresp", i), resp, vec[i].exp_resp);
        chk($sformatf("v%0d_rdata", i), rd, vec[i].exp_rdata);
      end
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vec[i].exp_lat));
      chk($sformatf("v%0d_en_count", i), 64'(n_en - en0), 64'(vec[i].exp_en));
    end

    // Zero-strobe write, then B stalled 5 cycles with a read waiting
    en0 = n_en;
    s_awaddr = 16'h0020; s_wdata = 64'h55; s_wstrb = 8'h00; s_awvalid = 1'b1; s_wvalid = 1'b1;
    n = 0;
    while (!s_awready && n < 50) begin @(negedge msoc_clk); n++; end
    if (!s_awready) timeout("strb0_accept");
    @(negedge msoc_clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; n = 0;
    while (!s_bvalid && n < 50) begin @(negedge msoc_clk); n++; end
    if (!s_bvalid) timeout("strb0_bvalid");
    chk("strb0_bresp", s_bresp, 2'b00);
    s_araddr = 16'h0010; s_arvalid = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(negedge msoc_clk);
      if (!s_bvalid || s_arready || s_awready) saw = 1'b1;
    end
    chk("bstall_hold_no_accept", saw, 1'b0);
    s_bready = 1'b1;
    @(negedge msoc_clk);
    s_bready = 1'b0; s_arvalid = 1'b0;
    repeat (2) @(negedge msoc_clk);
    chk("strb0_no_en", 64'(n_en - en0), 64'd0);

    // Both sides pending: order must be write, read, write, read
    we_log.delete();
    sb_off = 1'b1;
    fork
      begin
        logic [1:0] r1; int l1;
        axi_wr(16'h0100, 64'h1, 8'hFF, r1, l1);
        axi_wr(16'h0108, 64'h2, 8'hFF, r1, l1);
      end
      begin
        logic [1:0] r2; logic [63:0] d2; int l2;
        axi_rd(16'h0100, d2, r2, l2);
        chk("arb_rd1_data", d2, 64'h1);
        axi_rd(16'h0108, d2, r2, l2);
        chk("arb_rd2_data", d2, 64'h2);
      end
    join
    chk("arb_count", 64'(we_log.size()), 64'd4);
    if (we_log.size() == 4)
      chk("arb_order", {we_log[0], we_log[1], we_log[2], we_log[3]}, 4'b1010);
    sb_off = 1'b0;

    // Reset while waiting on read data
    exp_q.push_back(acc_t'{we: 1'b0, addr: 16'h0010, be: 8'hFF, data: 64'h0});
    s_araddr = 16'h0010; s_arvalid = 1'b1; n = 0;
    while (!s_arready && n < 50) begin @(negedge msoc_clk); n++; end
    if (!s_arready) timeout("rst_rd_accept");
    @(negedge msoc_clk);
    s_arvalid = 1'b0; n = 0;
    while (!spisd_en && n < 50) begin @(negedge msoc_clk); n++; end
    if (!spisd_en) timeout("rst_rd_issue");
    sys_rst = 1'b1;
    @(negedge msoc_clk);
    sys_rst = 1'b0;
    en0 = n_en;
    saw = s_rvalid;
    repeat (8) begin
      @(negedge msoc_clk);
      if (s_rvalid) saw = 1'b1;
    end
    chk("rst_mid_no_rvalid", saw, 1'b0);
    chk("rst_mid_no_en", 64'(n_en - en0), 64'd0);

    exp_q.push_back(acc_t'{we: 1'b0, addr: 16'h8000, be: 8'hFF, data: 64'h0});
    axi_rd(16'h8000, rd, resp, lat);
    chk("post_rst_rdata", rd, 64'h1234);
    chk("post_rst_rresp", resp, 2'b00);
    chk("post_rst_latency", 64'(lat), 64'd3);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
